// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin packet arbiter.
package rr_arb_pkg;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} rr_state_t;

  localparam int MAX_N = 16;

  // Index of the set bit in a one-hot vector; 0 when no bit is set.
  function automatic logic [3:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++)
      if (oh[i]) idx = 4'(i);
    return idx;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: rotate requests so ptr sits at bit 0,
// find the first set bit, then map the offset back to a requester index.
module rr_priority_pick
  import rr_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx,
  output logic [N-1:0]     onehot
);

  logic [N-1:0]     rot;
  logic [N-1:0]     first;
  logic [MAX_N-1:0] first_x;
  logic [IDX_W:0]   k;
  logic [IDX_W:0]   sum;

  always_comb begin
    rot = '0;
    k   = '0;
    for (int j = 0; j < N; j++) begin
      k = (IDX_W+1)'(j) + {1'b0, ptr};
      if (k >= (IDX_W+1)'(N)) k = k - (IDX_W+1)'(N);
      rot[j] = req[k[IDX_W-1:0]];
    end

    // Descending scan so the lowest rotated position wins.
    first = '0;
    for (int j = N - 1; j >= 0; j--)
      if (rot[j]) begin
        first    = '0;
        first[j] = 1'b1;
      end

    first_x          = '0;
    first_x[N-1:0]   = first;
    sum = {1'b0, ptr} + (IDX_W+1)'(onehot_to_idx(first_x));
    if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);

    any = |req;
    idx = sum[IDX_W-1:0];
    onehot = '0;
    for (int i = 0; i < N; i++)
      onehot[i] = any && (idx == IDX_W'(i));
  end

endmodule

// File: rtl/rr_packet_arbiter.sv
// N-way round-robin arbiter with per-packet lock onto one valid/ready channel.
// Priority rotates past a requester only once its last beat is accepted.
module rr_packet_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_data,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic           out_last,
  input  logic           out_ready,
  output logic [N-1:0]   grant,
  output logic           busy
);

  localparam int IDX_W = $clog2(N);

  rr_state_t        state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [IDX_W-1:0] owner, owner_nxt;
  logic [IDX_W-1:0] win_idx, idx, idx_inc;
  logic [N-1:0]     win_oh, owner_oh;
  logic             win_any, active, done;

  rr_priority_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
    .req    (req_valid),
    .ptr    (ptr),
    .any    (win_any),
    .idx    (win_idx),
    .onehot (win_oh)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      owner <= owner_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    req_ready = '0;
    grant     = '0;
    owner_oh  = '0;

    idx     = (state == LOCKED) ? owner : win_idx;
    idx_inc = (idx == IDX_W'(N - 1)) ? '0 : idx + 1'b1;
    // Outputs are held quiet while reset is asserted, whatever the inputs do.
    active  = rst && ((state == LOCKED) || win_any);
    busy    = rst && (state == LOCKED);

    for (int i = 0; i < N; i++) begin
      owner_oh[i] = (owner == IDX_W'(i));
      if (idx == IDX_W'(i)) out_data = req_data[i*W +: W];
    end

    if (active) begin
      out_valid      = req_valid[idx];
      out_last       = req_last[idx];
      req_ready[idx] = out_ready;
      grant          = (state == LOCKED) ? owner_oh : win_oh;
    end

    done = out_valid && out_ready && out_last;

    case (state)
      IDLE: begin
        if (active) begin
          if (done) begin
            ptr_nxt = idx_inc;
          end else begin
            // Commit even on a stalled offer so the channel stays stable.
            state_nxt = LOCKED;
            owner_nxt = idx;
          end
        end
      end
      LOCKED: begin
        if (done) begin
          state_nxt = IDLE;
          ptr_nxt   = idx_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Directed bench for rr_packet_arbiter (N=4, W=8): inputs change just after
// the falling edge, outputs are checked 1ns later, state commits on the rise.
module tb_rr_packet_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic           out_ready;
  logic [N-1:0]   grant;
  logic           busy;

  int checks   = 0;
  int failures = 0;

  rr_packet_arbiter #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .grant     (grant),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester i presents 0xA0+i by default.
  task automatic set_default_data();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 8'(8'hA0 + i);
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 4'b1111; req_last = 4'b1111; out_ready = 1'b1;
    set_default_data();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL release_grant got=%b exp=0001", grant); end
    checks++; if (out_data !== 8'hA0) begin failures++; $display("FAIL release_data got=%h exp=a0", out_data); end
  endtask

  // Previous cycle accepted requester 0, so rotation continues from 1.
  task automatic test_round_robin();
    logic [N-1:0] exp_g [4];
    logic [W-1:0] exp_d [4];
    exp_g[0] = 4'b0010; exp_g[1] = 4'b0100; exp_g[2] = 4'b1000; exp_g[3] = 4'b0001;
    exp_d[0] = 8'hA1;   exp_d[1] = 8'hA2;   exp_d[2] = 8'hA3;   exp_d[3] = 8'hA0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      checks++; if (grant !== exp_g[c]) begin failures++; $display("FAIL rr_grant[%0d] got=%b exp=%b", c, grant, exp_g[c]); end
      checks++; if (req_ready !== exp_g[c]) begin failures++; $display("FAIL rr_ready[%0d] got=%b exp=%b", c, req_ready, exp_g[c]); end
      checks++; if (out_data !== exp_d[c]) begin failures++; $display("FAIL rr_data[%0d] got=%h exp=%h", c, out_data, exp_d[c]); end
    end
  endtask

  // ptr=1: requester 1 sends a 3-beat packet while the others keep requesting.
  task automatic test_packet_lock();
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      req_valid = 4'b1111;
      req_last  = (b == 2) ? 4'b1111 : 4'b1101;
      req_data[1*W +: W] = 8'(8'h10 + b);
      #1;
      checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL pkt_grant[%0d] got=%b exp=0010", b, grant); end
      checks++; if (out_data !== 8'(8'h10 + b)) begin failures++; $display("FAIL pkt_data[%0d] got=%h exp=%h", b, out_data, 8'(8'h10 + b)); end
      checks++; if (busy !== (b != 0)) begin failures++; $display("FAIL pkt_busy[%0d] got=%b exp=%b", b, busy, (b != 0)); end
    end
    checks++; if (out_last !== 1'b1) begin failures++; $display("FAIL pkt_last got=%b exp=1", out_last); end
  endtask

  // Requester 2 wins with out_ready low; a late request from 0 must not steal it.
  task automatic test_stall();
    @(negedge clk);
    req_valid = 4'b1100; req_last = 4'b1111; out_ready = 1'b0;
    req_data[2*W +: W] = 8'h22;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stall_idle_busy got=%b exp=0", busy); end
    checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL stall_first_grant got=%b exp=0100", grant); end
    checks++; if (dut.ptr !== 2'd2) begin failures++; $display("FAIL stall_ptr_start got=%0d exp=2", dut.ptr); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_valid = 4'b1101;
      #1;
      checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL stall_grant[%0d] got=%b exp=0100", c, grant); end
      checks++; if (out_data !== 8'h22) begin failures++; $display("FAIL stall_data[%0d] got=%h exp=22", c, out_data); end
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL stall_ready[%0d] got=%b exp=0000", c, req_ready); end
      checks++; if (dut.ptr !== 2'd2) begin failures++; $display("FAIL stall_ptr[%0d] got=%0d exp=2", c, dut.ptr); end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL stall_accept_ready got=%b exp=0100", req_ready); end
  endtask

  // ptr=3 after the stalled packet; lone requester 2 streams single beats.
  task automatic test_back_to_back();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_valid = 4'b0100; req_last = 4'b1111;
      #1;
      checks++; if (dut.ptr !== 2'd3) begin failures++; $display("FAIL b2b_ptr[%0d] got=%0d exp=3", c, dut.ptr); end
      checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL b2b_grant[%0d] got=%b exp=0100", c, grant); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy[%0d] got=%b exp=0", c, busy); end
    end
    @(negedge clk);
    req_valid = 4'b1001;
    #1;
    checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL wrap_grant got=%b exp=1000", grant); end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    checks++; if (dut.ptr !== 2'd0) begin failures++; $display("FAIL wrap_ptr got=%0d exp=0", dut.ptr); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL idle_out_valid got=%b exp=0", out_valid); end
  endtask

  // Requester 3 starts a 4-beat packet; reset lands off the clock edge.
  task automatic test_async_reset();
    @(negedge clk);
    req_valid = 4'b1000; req_last = 4'b0000; out_ready = 1'b1;
    #1;
    checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL ar_grant got=%b exp=1000", grant); end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ar_busy_locked got=%b exp=1", busy); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ar_busy got=%b exp=0", busy); end
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL ar_grant_reset got=%b exp=0000", grant); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ar_out_valid got=%b exp=0", out_valid); end
    @(negedge clk);
    rst = 1'b1; req_valid = 4'b1111; req_last = 4'b1111;
    #1;
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL ar_release_grant got=%b exp=0001", grant); end
    checks++; if (dut.ptr !== 2'd0) begin failures++; $display("FAIL ar_ptr got=%0d exp=0", dut.ptr); end
  endtask

  initial begin
    rst = 1'b0; req_valid = '0; req_last = '0; req_data = '0; out_ready = 1'b0;
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_stall();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
